// File: rtl/mem_ctrl_pkg.sv
// Shared codes for the memory sequencer: access sizes, FSM states, requester ids.
// Imported by mem_ctrl and its round-robin arbiter.
package mem_ctrl_pkg;

  localparam int XLEN_WIDTH     = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int MEM_ADDR_WIDTH = 16;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Bit positions of the two requesters inside the arbiter req/gnt vectors
  localparam int IF_BIT  = 0;
  localparam int LSU_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR      = 2'd3
  } mem_state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } req_owner_t;

  // Index of the final byte written for a store; size 3 is handled like a word
  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: last_byte_idx = 2'd0;
      MEM_SIZE_H: last_byte_idx = 2'd1;
      default:    last_byte_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The favoured requester flips to the other
// one after every grant, so continuous requesters strictly alternate.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = req;
    endcase
  end

  // After reset the LSU is favoured; after a grant the loser becomes favoured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b1;
    end else if (advance) begin
      prio_q <= gnt[IF_BIT];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sequencer in front of the byte-array ram: arbitrates IF and LSU onto the ram
// read port and single byte write port, splitting half/word stores into bytes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_we,
  input  logic [1:0]      lsu_size,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_rsp_valid,
  output logic [XLEN-1:0] lsu_rsp_data,
  output logic [XLEN-1:0] ram_addr,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            ram_we,
  output logic [XLEN-1:0] ram_waddr,
  output logic [XLEN-1:0] ram_wdata
);

  mem_state_t            state_q;
  mem_state_t            state_d;
  req_owner_t            owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            last_q;
  logic [1:0]            cnt_q;
  logic [XLEN-1:0]       wdata_q;

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  accept;
  logic                  grant_lsu;
  logic                  accept_store;
  logic [ADDR_WIDTH-1:0] accept_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BYTE_WIDTH-1:0] wr_byte;
  logic                  wr_last;
  logic                  unused_addr_bits;

  assign req          = {lsu_req_valid, if_req_valid};
  assign accept       = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign grant_lsu    = gnt[LSU_BIT];
  assign accept_store = grant_lsu && lsu_we;
  assign accept_addr  = grant_lsu ? lsu_addr[ADDR_WIDTH-1:0] : if_addr[ADDR_WIDTH-1:0];

  // Byte address wraps within the ram window; bytes leave LSB first
  assign wr_addr = addr_q + ADDR_WIDTH'(cnt_q);
  assign wr_byte = wdata_q[{cnt_q, 3'b000} +: BYTE_WIDTH];
  assign wr_last = (cnt_q == last_q);

  assign unused_addr_bits = ^{if_addr[XLEN-1:ADDR_WIDTH], lsu_addr[XLEN-1:ADDR_WIDTH]};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = accept_store ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_IDLE;
      ST_WR: begin
        if (wr_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready only in IDLE and only to the arbiter winner; write port live only in WR
  always_comb begin
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = '0;
    ram_wdata     = '0;
    case (state_q)
      ST_IDLE: begin
        if_req_ready  = gnt[IF_BIT];
        lsu_req_ready = gnt[LSU_BIT];
      end
      ST_WR: begin
        ram_we    = 1'b1;
        ram_waddr = XLEN'(wr_addr);
        ram_wdata = XLEN'(wr_byte);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q       <= REQ_IF;
      addr_q        <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      wdata_q       <= '0;
      ram_addr      <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
    end else begin
      if_rsp_valid  <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant_lsu ? REQ_LSU : REQ_IF;
            addr_q  <= accept_addr;
            last_q  <= last_byte_idx(lsu_size);
            wdata_q <= lsu_wdata;
            cnt_q   <= '0;
            if (!accept_store) begin
              ram_addr <= XLEN'(accept_addr);
            end
          end
        end
        ST_RD_DATA: begin
          if (owner_q == REQ_LSU) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_data  <= ram_rdata;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= ram_rdata;
          end
        end
        ST_WR: begin
          if (wr_last) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_data  <= '0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
